dcache_arbiter: RTL and testbench

//  Round-robin arbiter that shares one data-cache port among NUM_REQ CPU-side requesters
//  (e.g. memory unit, debug/DMA port), all using the dcache_interface cpu_req_t/cpu_res_t types.

---
 rtl/dcache_arbiter_pkg.sv | 32 +++
 rtl/dcache_arbiter_rr_picker.sv | 30 +++
 rtl/dcache_arbiter.sv | 154 +++++++++++++++
 tb/tb_dcache_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arbiter_pkg.sv
// Shared types for the data-cache arbiter: CPU-side request/response structs and FSM state.
// The bench imports this package so it can observe the arbiter state.
package dcache_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       valid;
        logic       rw;
        word_t      addr;
        word_t      data;
        logic [3:0] wmask;
    } cpu_req_t;

    typedef struct packed {
        logic  ready;
        word_t data;
    } cpu_res_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Width of the WAIT-cycle counter; at least one bit even for tiny limits.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dcache_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first valid requester at or above ptr_i, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                       any_valid_o
);

    localparam int GNT_W = $clog2(NUM_REQ);

    always_comb begin
        int idx;
        grant_o     = '0;
        any_valid_o = 1'b0;
        // Scan from the farthest offset down so the nearest valid one wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (valid_i[GNT_W'(idx)]) begin
                grant_o     = GNT_W'(idx);
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_arbiter.sv
// Round-robin arbiter sharing one dcache port among NUM_REQ requesters, one transaction in flight.
// All outputs are registered; the response is routed only to the granted requester.
module dcache_arbiter
    import dcache_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  cpu_req_t [NUM_REQ-1:0]     req_i,
    output cpu_res_t [NUM_REQ-1:0]     res_o,
    output cpu_req_t                   cache_req_o,
    input  cpu_res_t                   cache_res_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                       timeout_o,
    output arb_state_t                 state_o
);

    localparam int GNT_W = $clog2(NUM_REQ);

    // Handshake: a requester raises valid with stable fields and keeps them until its
    // res_o ready pulse; cache_req_o.valid is a one-cycle start pulse, and the cache
    // answers with a one-cycle cache_res_i.ready that is only honoured while waiting.

    arb_state_t                 state_q, state_d;
    logic [GNT_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [GNT_W-1:0]           grant_q, grant_d;
    cpu_req_t                   cache_req_q, cache_req_d;
    cpu_res_t [NUM_REQ-1:0]     res_q, res_d;
    logic                       timeout_q, timeout_d;

    logic [NUM_REQ-1:0]         valid_vec;
    logic [GNT_W-1:0]           pick;
    logic                       any_valid;
    logic                       wait_expired;

    always_comb begin
        valid_vec = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            valid_vec[k] = req_i[k].valid;
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .valid_i     (valid_vec),
        .ptr_i       (rr_ptr_q),
        .grant_o     (pick),
        .any_valid_o (any_valid)
    );

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = cnt_width(TIMEOUT);

            logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

            always_comb begin
                wait_cnt_d = '0;
                if (state_q == WAIT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_d;
                end
            end

            // Counter starts at 0 on the first WAIT cycle, so TIMEOUT-1 is the last one allowed.
            assign wait_expired = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign wait_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        grant_d           = grant_q;
        cache_req_d       = cache_req_q;
        cache_req_d.valid = 1'b0;
        res_d             = res_q;
        timeout_d         = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            res_d[k].ready = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d           = pick;
                    cache_req_d       = req_i[pick];
                    cache_req_d.valid = 1'b1;
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (cache_res_i.ready) begin
                    res_d[grant_q].data  = cache_res_i.data;
                    res_d[grant_q].ready = 1'b1;
                    state_d              = RESP;
                end else if (wait_expired) begin
                    res_d[grant_q].data  = '0;
                    res_d[grant_q].ready = 1'b1;
                    timeout_d            = 1'b1;
                    state_d              = RESP;
                end
            end
            RESP: begin
                rr_ptr_d = (grant_q == GNT_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cache_req_q <= '0;
            res_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cache_req_q <= cache_req_d;
            res_q       <= res_d;
            timeout_q   <= timeout_d;
        end
    end

    assign res_o       = res_q;
    assign cache_req_o = cache_req_q;
    assign busy_o      = (state_q != IDLE);
    assign grant_o     = grant_q;
    assign timeout_o   = timeout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Bench for dcache_arbiter: scoreboarded cache requests and responses, one task per scenario.
module tb_dcache_arbiter;
    import dcache_arbiter_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 8;

    logic                   clk;
    logic                   rst_n;
    cpu_req_t [NUM_REQ-1:0] req_i;
    cpu_res_t [NUM_REQ-1:0] res_o;
    cpu_req_t               cache_req_o;
    cpu_res_t               cache_res_i;
    logic                   busy_o;
    logic [0:0]             grant_o;
    logic                   timeout_o;
    arb_state_t             state_o;

    dcache_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .res_o       (res_o),
        .cache_req_o (cache_req_o),
        .cache_res_i (cache_res_i),
        .busy_o      (busy_o),
        .grant_o     (grant_o),
        .timeout_o   (timeout_o),
        .state_o     (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test sequence ended");
        $fatal(1);
    end

    int          total;
    int          bad;
    logic [32:0] exp_q[$];    // {requester, response data}
    logic [69:0] creq_q[$];   // {grant, addr, data, wmask, rw}
    logic [31:0] cdata_q[$];  // data the cache model returns, per transaction
    int          cache_delay; // cycles from start pulse to cache ready; 0 = never answers
    int          cd;
    logic [31:0] cur_data;
    logic [1:0]  got_ready;
    int          n_issue;
    int          n_ready[NUM_REQ];

    // One clock step: scoreboard both DUT outputs at the negedge, then drive the cache model.
    task automatic cycle();
        logic [32:0] e;
        logic [69:0] c;
        @(negedge clk);
        got_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (res_o[k].ready === 1'b1) begin
                got_ready[k] = 1'b1;
                n_ready[k]++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected req=%0d data=%h required=no response", k, res_o[k].data);
                end else begin
                    e = exp_q.pop_front();
                    if ({1'(k), res_o[k].data} !== e) begin
                        bad++;
                        $display("FAIL resp req/data got=%0d/%h required=%0d/%h",
                                 k, res_o[k].data, e[32], e[31:0]);
                    end
                end
            end
        end
        if (cache_req_o.valid === 1'b1) begin
            n_issue++;
            total++;
            if (creq_q.size() == 0) begin
                bad++;
                $display("FAIL cache_req_unexpected addr=%h required=no request", cache_req_o.addr);
            end else begin
                c = creq_q.pop_front();
                if ({grant_o, cache_req_o.addr, cache_req_o.data, cache_req_o.wmask, cache_req_o.rw} !== c) begin
                    bad++;
                    $display("FAIL cache_req grant/addr/data/wmask/rw got=%0d/%h/%h/%h/%0d required=%0d/%h/%h/%h/%0d",
                             grant_o, cache_req_o.addr, cache_req_o.data, cache_req_o.wmask, cache_req_o.rw,
                             c[69], c[68:37], c[36:5], c[4:1], c[0]);
                end
            end
        end
        cache_res_i.ready = 1'b0;
        cache_res_i.data  = '0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                cache_res_i.ready = 1'b1;
                cache_res_i.data  = cur_data;
            end
        end
        if (cache_req_o.valid === 1'b1 && cache_delay > 0) begin
            cd       = cache_delay;
            cur_data = (cdata_q.size() > 0) ? cdata_q.pop_front() : 32'h0;
        end
    endtask

    // driver tasks
    task automatic set_req(input int k, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] wmask, input logic rw);
        req_i[k].valid = 1'b1;
        req_i[k].rw    = rw;
        req_i[k].addr  = addr;
        req_i[k].data  = data;
        req_i[k].wmask = wmask;
    endtask

    task automatic push_expect(input int k, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] wmask, input logic rw, input logic [31:0] cdata,
                               input bit timed_out);
        creq_q.push_back({1'(k), addr, data, wmask, rw});
        if (timed_out) begin
            exp_q.push_back({1'(k), 32'h0});
        end else begin
            cdata_q.push_back(cdata);
            exp_q.push_back({1'(k), cdata});
        end
    endtask

    task automatic wait_resp(input int k, input bit drop, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            cycle();
            n++;
            if (got_ready[k]) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL resp_wait req=%0d got=no ready after %0d cycles required=ready", k, n);
        end
        if (drop) req_i = '0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_i       = '0;
        cache_res_i = '0;
        repeat (3) @(negedge clk);
        total++;
        if (state_o !== IDLE || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state state/busy/timeout got=%0d/%b/%b required=0/0/0", state_o, busy_o, timeout_o);
        end
        total++;
        if (grant_o !== 1'b0 || cache_req_o !== '0 || res_o !== '0) begin
            bad++;
            $display("FAIL reset_outputs grant/cache_req/res got=%0d/%h/%h required=0/0/0", grant_o, cache_req_o, res_o);
        end
        rst_n = 1'b1;
        repeat (2) cycle();
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle busy got=%b required=0", busy_o);
        end
    endtask

    task automatic test_single_read();
        int base_issue;
        int base_r1;
        int n;
        cache_delay = 2;
        base_issue  = n_issue;
        base_r1     = n_ready[1];
        set_req(0, 32'h100, 32'h0, 4'h0, 1'b0);
        push_expect(0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        wait_resp(0, 1'b1, n);
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL read_latency got=%0d required=4", n);
        end
        total++;
        if (n_issue - base_issue != 1) begin
            bad++;
            $display("FAIL read_start_pulses got=%0d required=1", n_issue - base_issue);
        end
        total++;
        if (n_ready[1] - base_r1 != 0) begin
            bad++;
            $display("FAIL read_other_ready got=%0d required=0", n_ready[1] - base_r1);
        end
        cycle();
        total++;
        if (res_o[0].ready !== 1'b0 || res_o[0].data !== 32'hDEADBEEF || state_o !== IDLE) begin
            bad++;
            $display("FAIL read_after ready/data/state got=%b/%h/%0d required=0/deadbeef/0",
                     res_o[0].ready, res_o[0].data, state_o);
        end
    endtask

    task automatic test_write();
        logic [31:0] cdata;
        int n;
        cache_delay = 1;
        cdata = $urandom | 32'h1;
        set_req(1, 32'h204, 32'h12345678, 4'hF, 1'b1);
        push_expect(1, 32'h204, 32'h12345678, 4'hF, 1'b1, cdata, 1'b0);
        wait_resp(1, 1'b1, n);
        total++;
        if (grant_o !== 1'b1 || n != 3) begin
            bad++;
            $display("FAIL write grant/latency got=%0d/%0d required=1/3", grant_o, n);
        end
        total++;
        if (res_o[0].data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_other_data_held got=%h required=deadbeef", res_o[0].data);
        end
    endtask

    task automatic test_contention();
        logic [31:0] d0;
        logic [31:0] d1;
        int n;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cache_delay = $urandom_range(1, 3);
        d0 = $urandom;
        d1 = $urandom;
        set_req(0, 32'h300, d0, 4'h0, 1'b0);
        set_req(1, 32'h400, d1, 4'h3, 1'b1);
        // both held valid: rotation from reset must alternate 0,1,0,1
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) push_expect(0, 32'h300, d0, 4'h0, 1'b0, $urandom, 1'b0);
            else            push_expect(1, 32'h400, d1, 4'h3, 1'b1, $urandom, 1'b0);
        end
        for (int t = 0; t < 4; t++) begin
            wait_resp(t % 2, t == 3, n);
        end
        cycle();
        total++;
        if (exp_q.size() != 0 || creq_q.size() != 0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL contention_drain exp/creq/busy got=%0d/%0d/%b required=0/0/0",
                     exp_q.size(), creq_q.size(), busy_o);
        end
    endtask

    task automatic test_timeout();
        int wstart;
        int tpos;
        int rpos;
        int pulses;
        int n;
        logic [31:0] cdata;
        cache_delay = 0;
        wstart = -1;
        tpos   = -1;
        rpos   = -1;
        pulses = 0;
        set_req(0, 32'h500, 32'h0, 4'h0, 1'b0);
        push_expect(0, 32'h500, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (state_o === WAIT && wstart < 0) wstart = i;
            if (timeout_o === 1'b1) begin
                pulses++;
                if (tpos < 0) tpos = i;
            end
            if (got_ready[0] && rpos < 0) begin
                rpos  = i;
                req_i = '0;
            end
        end
        total++;
        if (pulses != 1 || tpos - wstart != TIMEOUT) begin
            bad++;
            $display("FAIL timeout_pulse count/offset got=%0d/%0d required=1/%0d", pulses, tpos - wstart, TIMEOUT);
        end
        total++;
        if (rpos != tpos) begin
            bad++;
            $display("FAIL timeout_resp_cycle got=%0d required=%0d", rpos, tpos);
        end
        // timed-out grant 0 still advances the pointer, so requester 1 wins next
        cache_delay = 1;
        cdata = $urandom | 32'h1;
        set_req(0, 32'h600, 32'h0, 4'h0, 1'b0);
        set_req(1, 32'h700, 32'hCAFEF00D, 4'h1, 1'b1);
        push_expect(1, 32'h700, 32'hCAFEF00D, 4'h1, 1'b1, cdata, 1'b0);
        wait_resp(1, 1'b1, n);
        total++;
        if (n != 3 || timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_followup latency/timeout got=%0d/%b required=3/0", n, timeout_o);
        end
    endtask

    task automatic test_stray_ready();
        int seen;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            seen += int'(got_ready[0]) + int'(got_ready[1]);
            cache_res_i.ready = 1'b1;
            cache_res_i.data  = 32'hBAD0BAD0;
        end
        cycle();
        seen += int'(got_ready[0]) + int'(got_ready[1]);
        total++;
        if (seen != 0 || state_o !== IDLE || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL stray_ready readies/state/busy got=%0d/%0d/%b required=0/0/0", seen, state_o, busy_o);
        end
        total++;
        if (res_o[0].data !== 32'h0) begin
            bad++;
            $display("FAIL stray_ready_data got=%h required=0", res_o[0].data);
        end
    endtask

    task automatic test_mid_reset();
        int i;
        cache_delay = 0;
        set_req(1, 32'h800, 32'h55AA55AA, 4'hC, 1'b1);
        push_expect(1, 32'h800, 32'h55AA55AA, 4'hC, 1'b1, 32'h0, 1'b1);
        i = 0;
        while (state_o !== WAIT && i < 10) begin
            cycle();
            i++;
        end
        total++;
        if (state_o !== WAIT) begin
            bad++;
            $display("FAIL mid_reset_reach_wait state got=%0d required=2", state_o);
        end
        cycle();
        rst_n = 1'b0;
        #1;
        total++;
        if (state_o !== IDLE || busy_o !== 1'b0 || grant_o !== 1'b0 || timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_state state/busy/grant/timeout got=%0d/%b/%0d/%b required=0/0/0/0",
                     state_o, busy_o, grant_o, timeout_o);
        end
        total++;
        if (cache_req_o !== '0 || res_o !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs cache_req/res got=%h/%h required=0/0", cache_req_o, res_o);
        end
        req_i = '0;
        exp_q.delete();
        creq_q.delete();
        cdata_q.delete();
        cd = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        total++;
        if (state_o !== IDLE || busy_o !== 1'b0 || cache_req_o.valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_release state/busy/valid got=%0d/%b/%b required=0/0/0",
                     state_o, busy_o, cache_req_o.valid);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cache_delay = 0;
        cd          = 0;
        cur_data    = '0;
        got_ready   = '0;
        n_issue     = 0;
        n_ready[0]  = 0;
        n_ready[1]  = 0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_timeout();
        test_stray_ready();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
